// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the program counter, issues word addresses to a
// synchronous instruction RAM (one-cycle read latency) and buffers the returned
// words in a 2-entry FIFO that feeds decode over a valid/ready handshake.
// A redirect flushes both the RAM word in flight and everything buffered.
module instr_fetch #(
  parameter int ADDRESS_BUS_WIDTH = 6,
  parameter int INSTRUCTION_WIDTH = 36,
  parameter int RESET_PC          = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [ADDRESS_BUS_WIDTH-1:0] imem_addr,
  output logic                         imem_read_not_write,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_data,
  input  logic                         redirect_valid,
  input  logic [ADDRESS_BUS_WIDTH-1:0] redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTRUCTION_WIDTH-1:0] out_instr,
  output logic [ADDRESS_BUS_WIDTH-1:0] out_pc
);

  localparam logic [ADDRESS_BUS_WIDTH-1:0] RESET_PC_W = ADDRESS_BUS_WIDTH'(RESET_PC);

  logic [ADDRESS_BUS_WIDTH-1:0] pc;
  logic                         inflight;
  logic [ADDRESS_BUS_WIDTH-1:0] inflight_pc;
  logic [1:0]                   count;

  // entry 0 is the head presented to decode, entry 1 sits behind it
  logic [INSTRUCTION_WIDTH-1:0] head_instr, tail_instr;
  logic [ADDRESS_BUS_WIDTH-1:0] head_pc, tail_pc;

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occupancy;

  assign imem_addr           = pc;
  assign imem_read_not_write = 1'b1;
  assign out_valid           = (count != 2'd0);
  assign out_instr           = head_instr;
  assign out_pc              = head_pc;

  // Handshake bookkeeping: only issue when the word would still fit after
  // everything already buffered or in flight has landed.
  always_comb begin
    pop       = out_valid && out_ready;
    push      = inflight && !redirect_valid;
    occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    issue     = !redirect_valid && (occupancy < 3'd2);
  end

  // Program counter and in-flight tag tracking the RAM read pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC_W;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      pc          <= redirect_pc;
      inflight    <= 1'b0;
    end else if (issue) begin
      pc          <= pc + 1'b1;
      inflight    <= 1'b1;
      inflight_pc <= pc;
    end else begin
      inflight    <= 1'b0;
    end
  end

  // Two-entry FIFO: pops shift the tail forward, pushes land in the first
  // free slot after any shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= 2'd0;
      head_instr <= '0;
      head_pc    <= '0;
      tail_instr <= '0;
      tail_pc    <= '0;
    end else if (redirect_valid) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b01: begin
          head_instr <= tail_instr;
          head_pc    <= tail_pc;
          count      <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) begin
            head_instr <= imem_data;
            head_pc    <= inflight_pc;
          end else begin
            tail_instr <= imem_data;
            tail_pc    <= inflight_pc;
          end
          count <= count + 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_instr <= imem_data;
            head_pc    <= inflight_pc;
          end else begin
            head_instr <= tail_instr;
            head_pc    <= tail_pc;
            tail_instr <= imem_data;
            tail_pc    <= inflight_pc;
          end
        end
        default: begin
          count <= count;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, backpressure, redirect, redirect
// during a stall, PC wrap (second instance with RESET_PC = 62) and mid-stream reset.
module tb_instr_fetch;

  localparam int AW = 6;
  localparam int IW = 36;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] imem_addr;
  logic          imem_read_not_write;
  logic [IW-1:0] imem_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;

  logic [AW-1:0] w_imem_addr;
  logic          w_imem_read_not_write;
  logic [IW-1:0] w_imem_data;
  logic          w_redirect_valid = 1'b0;
  logic [AW-1:0] w_redirect_pc = '0;
  logic          w_out_valid;
  logic          w_out_ready = 1'b1;
  logic [IW-1:0] w_out_instr;
  logic [AW-1:0] w_out_pc;

  logic [IW-1:0] mem [64];
  int            checks = 0;
  int            errors = 0;
  logic          mon_en = 1'b0;

  always #5 clk = ~clk;

  instr_fetch #(.ADDRESS_BUS_WIDTH(AW), .INSTRUCTION_WIDTH(IW), .RESET_PC(0)) u_dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_read_not_write(imem_read_not_write), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );

  instr_fetch #(.ADDRESS_BUS_WIDTH(AW), .INSTRUCTION_WIDTH(IW), .RESET_PC(62)) u_dut_wrap (
    .clk(clk), .rst(rst),
    .imem_addr(w_imem_addr), .imem_read_not_write(w_imem_read_not_write), .imem_data(w_imem_data),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_instr(w_out_instr), .out_pc(w_out_pc)
  );

  // synchronous RAMs with one-cycle registered read
  always @(posedge clk) begin
    imem_data   <= mem[imem_addr];
    w_imem_data <= mem[w_imem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // a push into a full FIFO without a pop would drop a word
  always @(negedge clk) begin
    if (mon_en && !rst)
      chk("fifo_overflow",
          {63'd0, (u_dut.count == 2'd2) && u_dut.push && !u_dut.pop}, 64'd0);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 36'hA00000000 | 36'(i);
    mem[0] = 36'h021000000;
    mem[1] = 36'h022000000;
    mem[2] = 36'h02300000A;

    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_rnw", imem_read_not_write, 1);
    chk("rst_instr", out_instr, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_wrap_addr", w_imem_addr, 62);

    // cycle 0
    rst = 1'b0; mon_en = 1'b1;
    chk("c0_addr", imem_addr, 0);
    chk("c0_valid", out_valid, 0);
    tick(); // c1
    chk("c1_valid", out_valid, 0);
    chk("c1_addr", imem_addr, 1);
    tick(); // c2
    chk("c2_valid", out_valid, 1);
    chk("c2_pc", out_pc, 0);
    chk("c2_instr", out_instr, 36'h021000000);
    chk("wrap_pc0", w_out_pc, 62);
    tick(); // c3
    chk("c3_pc", out_pc, 1);
    chk("c3_instr", out_instr, 36'h022000000);
    chk("wrap_pc1", w_out_pc, 63);
    tick(); // c4
    chk("c4_pc", out_pc, 2);
    chk("c4_instr", out_instr, 36'h02300000A);
    chk("wrap_pc2", w_out_pc, 0);
    tick(); // c5: stall begins
    chk("wrap_pc3", w_out_pc, 1);
    chk("wrap_valid", w_out_valid, 1);
    out_ready = 1'b0;
    chk("c5_pc", out_pc, 3);
    for (int c = 6; c <= 9; c++) begin
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_pc", out_pc, 3);
      chk("stall_instr", out_instr, 36'hA00000003);
      chk("stall_addr", imem_addr, 5);
    end
    tick(); // c10: release
    out_ready = 1'b1;
    chk("rel_pc3", out_pc, 3);
    for (int p = 4; p <= 6; p++) begin
      tick();
      chk("rel_valid", out_valid, 1);
      chk("rel_pc", out_pc, 64'(p));
      chk("rel_instr", out_instr, 36'hA00000000 | 36'(p));
    end
    tick(); // c14: redirect to 4, pop of pc 7 still valid
    chk("c14_pc", out_pc, 7);
    redirect_valid = 1'b1; redirect_pc = 6'h04;
    tick(); // c15
    redirect_valid = 1'b0;
    chk("rd_c15_valid", out_valid, 0);
    chk("rd_c15_addr", imem_addr, 4);
    tick(); // c16
    chk("rd_c16_valid", out_valid, 0);
    tick(); // c17
    chk("rd_c17_valid", out_valid, 1);
    chk("rd_c17_pc", out_pc, 4);
    chk("rd_c17_instr", out_instr, 36'hA00000004);
    tick(); // c18
    chk("rd_c18_pc", out_pc, 5);
    tick(); // c19
    chk("c19_pc", out_pc, 6);
    out_ready = 1'b0;
    tick(); // c20
    chk("c20_pc", out_pc, 6);
    tick(); // c21: redirect while stalled with FIFO full
    chk("c21_count", u_dut.count, 2);
    redirect_valid = 1'b1; redirect_pc = 6'h10;
    tick(); // c22
    redirect_valid = 1'b0;
    chk("rs_c22_valid", out_valid, 0);
    chk("rs_c22_addr", imem_addr, 6'h10);
    tick(); // c23
    chk("rs_c23_valid", out_valid, 0);
    tick(); // c24
    chk("rs_c24_valid", out_valid, 1);
    chk("rs_c24_pc", out_pc, 6'h10);
    chk("rs_c24_instr", out_instr, 36'hA00000010);
    tick(); tick(); // c26
    chk("rs_c26_pc", out_pc, 6'h10);
    chk("rs_c26_addr", imem_addr, 6'h12);
    tick(); // c27
    out_ready = 1'b1;
    chk("rs_c27_pc", out_pc, 6'h10);
    tick(); // c28
    chk("rs_c28_pc", out_pc, 6'h11);
    tick(); // c29
    chk("rs_c29_pc", out_pc, 6'h12);
    tick(); // c30
    out_ready = 1'b0;
    chk("c30_pc", out_pc, 6'h13);
    tick(); // c31
    chk("c31_count", u_dut.count, 2);
    tick(); // c32: reset with FIFO full
    chk("c32_valid", out_valid, 1);
    rst = 1'b1;
    tick(); // new cycle 0
    rst = 1'b0; out_ready = 1'b1;
    chk("mr_valid", out_valid, 0);
    chk("mr_addr", imem_addr, 0);
    chk("mr_pc", out_pc, 0);
    chk("mr_instr", out_instr, 0);
    tick(); // c1
    chk("mr_c1_valid", out_valid, 0);
    tick(); // c2
    chk("mr_c2_valid", out_valid, 1);
    chk("mr_c2_pc", out_pc, 0);
    chk("mr_c2_instr", out_instr, 36'h021000000);
    tick(); // c3
    chk("mr_c3_pc", out_pc, 1);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of the instruction RAM and downstream-facing to decode. Holds the program counter, drives the instruction RAM address with its read strobe tied to read, accounts for the RAM's one-cycle registered read latency, and buffers returned instructions in a 2-entry FIFO. Presents them to decode with a valid/ready handshake and supports branch redirect with flush of in-flight and buffered words.

## Interface
- ADDRESS_BUS_WIDTH, 6, instruction-word address width; PC is word-addressed, +1 per instruction.
- INSTRUCTION_WIDTH, 36, instruction word width.
- RESET_PC, 0, PC value loaded on reset.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_addr  out  ADDRESS_BUS_WIDTH  instruction RAM address; equals the internal PC register.
- imem_read_not_write  out  1  constant 1; fetch never writes the RAM.
- imem_data  in  INSTRUCTION_WIDTH  RAM read data; valid the cycle after an address is presented.
- redirect_valid  in  1  branch/jump taken; flush and reload PC.
- redirect_pc  in  ADDRESS_BUS_WIDTH  new fetch address when redirect_valid.
- out_valid  out  1  out_instr/out_pc hold a valid instruction.
- out_ready  in  1  decode accepts this cycle; transfer when out_valid && out_ready.
- out_instr  out  INSTRUCTION_WIDTH  instruction at FIFO head.
- out_pc  out  ADDRESS_BUS_WIDTH  address that instruction was fetched from.

## Operation
- State: pc, inflight flag plus inflight_pc tag, FIFO of 2 entries {instr, pc}, count 0..2.
- pop = out_valid && out_ready. issue = !redirect_valid && (count + inflight - pop) < 2.
- Issue: the RAM reads imem_addr every cycle; issue marks it as wanted: inflight <= 1, inflight_pc <= pc, pc <= pc + 1. No issue: inflight <= 0, pc holds.
- Capture: if inflight is set (and no redirect this cycle), imem_data with tag inflight_pc is pushed into the FIFO at the clock edge. Push and pop in the same cycle are both honoured; count unchanged.
- FIFO never overflows by construction of the issue rule; a push with count == 2 and no pop is a design error (assert in bench).
- Redirect (highest priority, overrides issue/capture/pop bookkeeping): count <= 0, inflight <= 0, pc <= redirect_pc. A pop occurring in the redirect cycle is still a valid transfer to decode. Back-to-back redirects: last one wins.
- PC wraps modulo 2^ADDRESS_BUS_WIDTH (max -> 0); no error.
- Reset: pc <= RESET_PC, inflight <= 0, count <= 0. Outputs after reset: imem_addr = RESET_PC, imem_read_not_write = 1, out_valid = 0, out_instr = 0, out_pc = 0 (FIFO storage cleared). rst mid-operation discards all in-flight and buffered words identically to redirect.
- out_instr/out_pc are FIFO head registers; stable while out_valid && !out_ready.

## Timing
- Cycle 0 = first cycle with rst low: issue address RESET_PC. Cycle 1: RAM data present, captured at end of cycle 1. Cycle 2: out_valid = 1, out_pc = RESET_PC.
- Fetch-to-out latency: 2 cycles. Redirect asserted in cycle N: out_valid = 0 in N+1 and N+2 (unless nothing to flush), first redirected instruction valid in N+3.
- Steady state with out_ready held high: one instruction per cycle, count = 1, inflight = 1.
- out_ready low: at most 2 further fetches complete into the FIFO, then issue stops; pc holds at next unfetched address. Resumes the cycle out_ready returns, no lost or duplicated words.

## Test plan
- Reset/stream: RAM preloaded 0x021000000, 0x022000000, 0x02300000A at 0..2, out_ready = 1 -> out_valid first high cycle 2, out_pc 0,1,2 on consecutive cycles with matching words.
- Backpressure: out_ready low cycles 3-7 -> FIFO fills to 2, pc stops advancing, out_instr stable; on release, sequence continues without gaps or duplicates.
- Redirect: redirect_valid with redirect_pc = 0x04 in cycle 5 -> no instruction from the old path appears after cycle 5; out_pc = 0x04 valid in cycle 8.
- Wrap: RESET_PC = 62 -> out_pc sequence 62, 63, 0, 1.
- Reset mid-stream: rst high one cycle with FIFO full -> next cycle out_valid = 0, imem_addr = RESET_PC; restart follows reset timing exactly.
- Redirect during stall: out_ready = 0, count = 2, redirect to 0x10 -> FIFO flushed, out_pc = 0x10 after 3 cycles.
